// File: rtl/button_event_gen.sv
// Turns debounced button levels into one-shot press/release/long/repeat events, one FSM per channel.
// Latency: every output is registered, pulses appear the cycle after the triggering edge; no backpressure.
module button_event_gen #(
    parameter int WIDTH             = 2,
    parameter int LONG_PRESS_CYCLES = 20,
    parameter int REPEAT_CYCLES     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    localparam int MAX_CYC = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // Terminal counts: the counter restarts at 0 on the qualifying edge, so it fires one below the period.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          repeat_q;
        logic          held_q;
        logic          btn;

        assign btn = debounced_signal[i];

        always_ff @(posedge clk) begin
            if (!rst) begin
                state     <= LOCKED;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                case (state)
                    // A button still down from reset must be let go before it can count.
                    LOCKED: begin
                        if (!btn) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (btn) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            press_q <= 1'b1;
                            held_q  <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!btn) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else if (cnt == LONG_LAST) begin
                            state  <= REPEAT;
                            cnt    <= '0;
                            long_q <= 1'b1;
                        end else begin
                            cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                        end
                    end
                    REPEAT: begin
                        if (!btn) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else if (cnt == REP_LAST) begin
                            cnt      <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                        end
                    end
                    default: begin
                        state  <= LOCKED;
                        cnt    <= '0;
                        held_q <= 1'b0;
                    end
                endcase
            end
        end

        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
        assign held[i]          = held_q;
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: fixed vector table, directed corner sequences and a randomized run
// checked cycle-by-cycle against a hold-length reference model.
module tb_button_event_gen;

    localparam int W    = 2;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    button_event_gen #(
        .WIDTH(W), .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .debounced_signal(din),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a press is tracked by how many further high samples followed the press edge.
    bit           m_locked [W];
    bit           m_pressed[W];
    int           m_h      [W];
    logic [W-1:0] e_press, e_rel, e_long, e_rep, e_held;

    int c_press[W], c_rel[W], c_long[W], c_rep[W];

    typedef struct {
        logic         r;
        logic [W-1:0] d;
        logic [W-1:0] p, rl, lg, rp, hd;
    } vec_t;
    vec_t tbl[14];

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_step(input logic r, input logic [W-1:0] d);
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int ch = 0; ch < W; ch++) begin
            if (!r) begin
                m_locked[ch] = 1; m_pressed[ch] = 0; m_h[ch] = 0;
            end else if (m_locked[ch]) begin
                if (!d[ch]) m_locked[ch] = 0;
            end else if (!m_pressed[ch]) begin
                if (d[ch]) begin
                    e_press[ch] = 1'b1; m_pressed[ch] = 1; m_h[ch] = 0;
                end
            end else if (d[ch]) begin
                m_h[ch]++;
                e_long[ch] = (m_h[ch] == LONG);
                e_rep[ch]  = (m_h[ch] > LONG) && ((m_h[ch] - LONG) % REP == 0);
            end else begin
                e_rel[ch] = 1'b1; m_pressed[ch] = 0;
            end
            e_held[ch] = m_pressed[ch];
        end
    endfunction

    function automatic void clear_counts();
        for (int ch = 0; ch < W; ch++) begin
            c_press[ch] = 0; c_rel[ch] = 0; c_long[ch] = 0; c_rep[ch] = 0;
        end
    endfunction

    task automatic apply(input logic r, input logic [W-1:0] d);
        @(negedge clk);
        rst = r;
        din = d;
        @(posedge clk);
        #1;
        model_step(r, d);
        check("press", press_pulse, e_press);
        check("release", release_pulse, e_rel);
        check("long", long_pulse, e_long);
        check("repeat", repeat_pulse, e_rep);
        check("held", held, e_held);
        for (int ch = 0; ch < W; ch++) begin
            c_press[ch] += int'(press_pulse[ch]);
            c_rel[ch]   += int'(release_pulse[ch]);
            c_long[ch]  += int'(long_pulse[ch]);
            c_rep[ch]   += int'(repeat_pulse[ch]);
        end
    endtask

    task automatic hold(input logic [W-1:0] d, input int n);
        for (int i = 0; i < n; i++) apply(1'b1, d);
    endtask

    initial begin
        // Short press on bit0, then bit1 held through reset.
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[3]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[4]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[5]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[6]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[7]  = '{1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[11] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[12] = '{1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        tbl[13] = '{1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};

        for (int v = 0; v < 14; v++) begin
            apply(tbl[v].r, tbl[v].d);
            check($sformatf("tbl%0d.press", v), press_pulse, tbl[v].p);
            check($sformatf("tbl%0d.release", v), release_pulse, tbl[v].rl);
            check($sformatf("tbl%0d.long", v), long_pulse, tbl[v].lg);
            check($sformatf("tbl%0d.repeat", v), repeat_pulse, tbl[v].rp);
            check($sformatf("tbl%0d.held", v), held, tbl[v].hd);
        end

        // Just short of long-press: 20 high samples.
        hold(2'b00, 3);
        clear_counts();
        hold(2'b01, 20);
        apply(1'b1, 2'b00);
        check_int("t2_short_long", c_long[0], 0);
        check_int("t2_short_release", c_rel[0], 1);

        // Exactly reaching long-press: 21 high samples.
        clear_counts();
        hold(2'b01, 21);
        check_int("t2_long_count", c_long[0], 1);
        check_int("t2_no_repeat_yet", c_rep[0], 0);
        apply(1'b1, 2'b00);

        // Long hold with three repeats, none after release.
        hold(2'b00, 2);
        clear_counts();
        hold(2'b01, 45);
        apply(1'b1, 2'b00);
        hold(2'b00, 10);
        check_int("t3_long", c_long[0], 1);
        check_int("t3_repeat", c_rep[0], 3);
        check_int("t3_release", c_rel[0], 1);

        // bit1 held across reset release for 30 cycles stays silent, then re-arms.
        clear_counts();
        apply(1'b0, 2'b10);
        hold(2'b10, 30);
        check_int("t4_locked_press", c_press[1], 0);
        check("t4_held", held, 2'b00);
        apply(1'b1, 2'b00);
        check_int("t4_no_release", c_rel[1], 0);
        apply(1'b1, 2'b10);
        check("t4_press", press_pulse, 2'b10);
        apply(1'b1, 2'b00);

        // Simultaneous presses, then reset while bit0 is repeating.
        hold(2'b00, 2);
        apply(1'b1, 2'b11);
        check("t5_both_press", press_pulse, 2'b11);
        hold(2'b01, 32);
        clear_counts();
        apply(1'b0, 2'b01);
        check("t5_rst_held", held, 2'b00);
        check("t5_rst_release", release_pulse, 2'b00);
        hold(2'b01, 6);
        check_int("t5_no_press", c_press[0], 0);
        check_int("t5_no_release", c_rel[0], 0);
        apply(1'b1, 2'b00);
        apply(1'b1, 2'b01);
        check_int("t5_rearm_press", c_press[0], 1);
        apply(1'b1, 2'b00);

        // Randomized runs with varied hold lengths and occasional resets.
        begin
            int           run[W];
            logic [W-1:0] lvl;
            logic         r;
            lvl = '0;
            for (int ch = 0; ch < W; ch++) run[ch] = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                for (int ch = 0; ch < W; ch++) begin
                    if (run[ch] == 0) begin
                        lvl[ch] = ~lvl[ch];
                        run[ch] = int'($urandom_range(1, 50));
                    end
                    run[ch]--;
                end
                r = ($urandom_range(0, 399) != 0);
                apply(r, lvl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
